// File: rtl/mpmc12_pkg.sv
// Shared types for the mpmc12 controller sequencer: command request layout,
// sequencer state encoding and the RMW command classifier.
package mpmc12_pkg;

  localparam int unsigned BLW_DEF           = 6;
  localparam int unsigned PRESET_CYCLES_DEF = 3;
  localparam int unsigned ALU_LATENCY_DEF   = 4;
  localparam int unsigned TO_CYCLES_DEF     = 1023;
  localparam bit          REFRESH_EN_DEF    = 1'b1;

  typedef enum logic [4:0] {
    CMD_NOP, CMD_LOAD, CMD_STORE,
    CMD_ADD, CMD_OR, CMD_AND, CMD_EOR, CMD_ASL, CMD_LSR,
    CMD_MIN, CMD_MAX, CMD_MINU, CMD_MAXU, CMD_CAS
  } fta_cmd_t;

  typedef struct packed {
    fta_cmd_t     cmd;
    logic         cyc;
    logic         we;
    logic [31:0]  sel;
    logic [31:0]  adr;
    logic [255:0] dat;
  } fta_cmd_request256_t;

  typedef enum logic [3:0] {
    IDLE, REFRESH, PRESET, WRITE, READ_CMD, READ_WAIT,
    ALU, ALU_PIPE, WRITE_TRAMP, WAIT_NACK
  } mpmc12_state_t;

  function automatic logic is_rmw_cmd(input fta_cmd_t c);
    case (c)
      CMD_ADD, CMD_OR, CMD_AND, CMD_EOR, CMD_ASL, CMD_LSR,
      CMD_MIN, CMD_MAX, CMD_MINU, CMD_MAXU, CMD_CAS: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mpmc12_hang_timer.sv
// Counts cycles while enabled, holds at the last count, and flags expiry
// for one cycle once armed (the owner clears it on the resulting state change).
module mpmc12_hang_timer #(
  parameter int unsigned CYCLES = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic arm,
  output logic expire
);
  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && cnt_q != LAST)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expire = en && arm && (cnt_q == LAST);

endmodule

// File: rtl/mpmc12_state_machine_fta.sv
// mpmc12 sequencer: refresh arbitration, burst write/read, RMW handoff and
// hang recovery between the command FIFO and the DDR application port.
module mpmc12_state_machine_fta
  import mpmc12_pkg::*;
#(
  parameter int unsigned BLW           = BLW_DEF,
  parameter int unsigned PRESET_CYCLES = PRESET_CYCLES_DEF,
  parameter int unsigned ALU_LATENCY   = ALU_LATENCY_DEF,
  parameter int unsigned TO_CYCLES     = TO_CYCLES_DEF,
  parameter bit          REFRESH_EN    = REFRESH_EN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                calib_complete,
  input  logic                rst_busy,
  input  logic                ref_req,
  output logic                ref_ack,
  input  logic                app_ref_ack,
  input  logic                rdy,
  input  logic                wdf_rdy,
  input  logic                fifo_v,
  input  fta_cmd_request256_t fifo_out,
  input  logic [BLW-1:0]      burst_len,
  input  logic                rd_data_valid,
  input  logic                rmw_hit,
  output mpmc12_state_t       state,
  output logic                app_en,
  output logic                app_wdf_wren,
  output logic [BLW-1:0]      req_cnt,
  output logic [BLW-1:0]      resp_cnt,
  output logic                timeout
);
  localparam int unsigned DLY_MAX = (PRESET_CYCLES > ALU_LATENCY) ? PRESET_CYCLES : ALU_LATENCY;
  localparam int unsigned DW      = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;

  mpmc12_state_t  state_q, state_d;
  logic [BLW-1:0] bl_q, bl_d, req_cnt_q, req_cnt_d, resp_cnt_q, resp_cnt_d;
  logic [DW-1:0]  dly_q, dly_d;
  logic           ref_ack_q, ref_ack_d, timeout_q, timeout_d;
  logic           to_expire, to_clr;
  logic           unused_fifo_bits;

  // Address/data travel on the datapath side; only the control fields matter here.
  assign unused_fifo_bits = ^{fifo_out.sel, fifo_out.adr, fifo_out.dat};

  always_comb begin
    state_d    = state_q;
    bl_d       = bl_q;
    req_cnt_d  = req_cnt_q;
    resp_cnt_d = resp_cnt_q;
    dly_d      = dly_q;
    if ((state_q == READ_CMD || state_q == READ_WAIT) && rd_data_valid && resp_cnt_q != bl_q)
      resp_cnt_d = resp_cnt_q + 1'b1;
    case (state_q)
      IDLE: if (calib_complete) begin
        if (REFRESH_EN && ref_req)
          state_d = REFRESH;
        else if (!rst_busy && fifo_v) begin
          state_d    = PRESET;
          req_cnt_d  = '0;
          resp_cnt_d = '0;
          bl_d       = burst_len;
          dly_d      = DW'(PRESET_CYCLES - 1);
        end
      end
      REFRESH: if (app_ref_ack) state_d = IDLE;
      PRESET: begin
        if (dly_q != '0)         dly_d   = dly_q - 1'b1;
        else if (!fifo_out.cyc)  state_d = IDLE;
        else if (fifo_out.we)    state_d = WRITE;
        else                     state_d = READ_CMD;
      end
      WRITE: if (rdy && wdf_rdy) begin
        if (req_cnt_q == bl_q) state_d   = IDLE;
        else                   req_cnt_d = req_cnt_q + 1'b1;
      end
      READ_CMD: if (rdy) begin
        if (req_cnt_q == bl_q) state_d   = READ_WAIT;
        else                   req_cnt_d = req_cnt_q + 1'b1;
      end
      READ_WAIT: if (rd_data_valid && resp_cnt_q == bl_q)
        state_d = is_rmw_cmd(fifo_out.cmd) ? ALU : WAIT_NACK;
      ALU: if (rmw_hit) begin
        state_d = ALU_PIPE;
        dly_d   = DW'(ALU_LATENCY - 1);
      end
      ALU_PIPE: begin
        if (dly_q != '0) dly_d   = dly_q - 1'b1;
        else             state_d = WRITE_TRAMP;
      end
      WRITE_TRAMP: begin
        req_cnt_d  = '0;
        resp_cnt_d = '0;
        state_d    = WRITE;
      end
      WAIT_NACK: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // Hang recovery wins over every other transition.
    if (to_expire) begin
      state_d    = IDLE;
      req_cnt_d  = '0;
      resp_cnt_d = '0;
    end
    ref_ack_d = (state_d == REFRESH);
    timeout_d = to_expire;
  end

  assign to_clr = (state_d != state_q) || (state_q == IDLE);

  mpmc12_hang_timer #(.CYCLES(TO_CYCLES)) u_hang_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (to_clr),
    .en     (state_q != IDLE),
    .arm    (calib_complete),
    .expire (to_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      bl_q       <= '0;
      req_cnt_q  <= '0;
      resp_cnt_q <= '0;
      dly_q      <= '0;
      ref_ack_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bl_q       <= bl_d;
      req_cnt_q  <= req_cnt_d;
      resp_cnt_q <= resp_cnt_d;
      dly_q      <= dly_d;
      ref_ack_q  <= ref_ack_d;
      timeout_q  <= timeout_d;
    end
  end

  assign state        = state_q;
  assign app_en       = (state_q == WRITE) || (state_q == READ_CMD);
  assign app_wdf_wren = (state_q == WRITE);
  assign req_cnt      = req_cnt_q;
  assign resp_cnt     = resp_cnt_q;
  assign ref_ack      = ref_ack_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_mpmc12_state_machine_fta.sv
// Bench for the mpmc12 sequencer: directed scenarios plus randomized
// transactions, each checked against expectations derived per transaction.
module tb_mpmc12_state_machine_fta;
  import mpmc12_pkg::*;

  localparam int unsigned BLW  = 6;
  localparam int unsigned PRE  = 3;
  localparam int unsigned ALAT = 4;
  localparam int unsigned TO   = 15;

  logic clk = 1'b0;
  logic rst, calib_complete, rst_busy, ref_req, ref_ack, app_ref_ack;
  logic rdy, wdf_rdy, fifo_v, rd_data_valid, rmw_hit;
  fta_cmd_request256_t fifo_out;
  logic [BLW-1:0] burst_len, req_cnt, resp_cnt;
  mpmc12_state_t state;
  logic app_en, app_wdf_wren, timeout;

  int n_chk  = 0;
  int n_fail = 0;
  bit q_rdy[$];
  bit q_wd[$];
  bit q_rdv[$];

  always #5 clk = ~clk;

  mpmc12_state_machine_fta #(
    .BLW(BLW), .PRESET_CYCLES(PRE), .ALU_LATENCY(ALAT), .TO_CYCLES(TO), .REFRESH_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .calib_complete(calib_complete), .rst_busy(rst_busy),
    .ref_req(ref_req), .ref_ack(ref_ack), .app_ref_ack(app_ref_ack),
    .rdy(rdy), .wdf_rdy(wdf_rdy), .fifo_v(fifo_v), .fifo_out(fifo_out),
    .burst_len(burst_len), .rd_data_valid(rd_data_valid), .rmw_hit(rmw_hit),
    .state(state), .app_en(app_en), .app_wdf_wren(app_wdf_wren),
    .req_cnt(req_cnt), .resp_cnt(resp_cnt), .timeout(timeout)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_state"}, int'(state), int'(IDLE));
    chk({tag, "_app_en"}, int'(app_en), 0);
    chk({tag, "_wren"}, int'(app_wdf_wren), 0);
    chk({tag, "_req"}, int'(req_cnt), 0);
    chk({tag, "_resp"}, int'(resp_cnt), 0);
    chk({tag, "_ref_ack"}, int'(ref_ack), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
  endtask

  // Presents a command from IDLE and walks the settle window; returns in the decoded state.
  task automatic issue(input fta_cmd_t c, input bit cyc, input bit we, input int bl);
    fifo_out     = '0;
    fifo_out.cmd = c;
    fifo_out.cyc = cyc;
    fifo_out.we  = we;
    fifo_out.adr = $urandom();
    fifo_out.dat = {8{$urandom()}};
    burst_len    = BLW'(bl);
    fifo_v       = 1'b1;
    step();
    chk("preset_entry", int'(state), int'(PRESET));
    chk("preset_req_clr", int'(req_cnt), 0);
    chk("preset_resp_clr", int'(resp_cnt), 0);
    fifo_v    = 1'b0;
    burst_len = BLW'($urandom_range(0, 63));
    for (int i = 1; i < PRE; i++) begin
      step();
      chk("preset_hold", int'(state), int'(PRESET));
    end
    step();
    if (!cyc)
      chk("decode_idle", int'(state), int'(IDLE));
    else begin
      chk("decode", int'(state), we ? int'(WRITE) : int'(READ_CMD));
      chk("first_app_en", int'(app_en), 1);
    end
  endtask

  task automatic write_phase(input int bl);
    int acc = 0;
    int cyc_in = 0;
    bit take;
    chk("wr_wren", int'(app_wdf_wren), 1);
    while (acc <= bl) begin
      rdy     = (q_rdy.size() > 0) ? q_rdy.pop_front() : (($urandom_range(0, 3) != 0) || cyc_in >= 6);
      wdf_rdy = (q_wd.size() > 0)  ? q_wd.pop_front()  : (($urandom_range(0, 3) != 0) || cyc_in >= 6);
      take = rdy && wdf_rdy;
      step();
      cyc_in++;
      if (take) acc++;
      if (acc == bl + 1) begin
        chk("wr_done_state", int'(state), int'(IDLE));
        chk("wr_done_req", int'(req_cnt), bl);
      end else begin
        chk("wr_state", int'(state), int'(WRITE));
        chk("wr_req", int'(req_cnt), acc);
      end
    end
    rdy = 1'b0;
    wdf_rdy = 1'b0;
  endtask

  task automatic read_phase(input int bl, input bit rmw);
    int acc = 0;
    int resp = 0;
    int cyc_in = 0;
    bit done = 1'b0;
    while (acc <= bl) begin
      rdy = (q_rdy.size() > 0) ? q_rdy.pop_front() : (($urandom_range(0, 3) != 0) || cyc_in >= 6);
      rd_data_valid = (q_rdv.size() > 0) ? q_rdv.pop_front() : ((resp < acc) && ($urandom_range(0, 1) != 0));
      step();
      cyc_in++;
      if (rdy) acc++;
      if (rd_data_valid) resp++;
      chk("rd_resp", int'(resp_cnt), mn(resp, bl));
      if (acc == bl + 1) begin
        chk("rd_to_wait", int'(state), int'(READ_WAIT));
        chk("rd_req_final", int'(req_cnt), bl);
      end else begin
        chk("rd_cmd_state", int'(state), int'(READ_CMD));
        chk("rd_req", int'(req_cnt), acc);
      end
    end
    rdy = 1'b0;
    cyc_in = 0;
    while (!done) begin
      rd_data_valid = (q_rdv.size() > 0) ? q_rdv.pop_front() : (($urandom_range(0, 2) != 0) || cyc_in >= 6);
      done = rd_data_valid && (mn(resp, bl) == bl);
      step();
      cyc_in++;
      if (rd_data_valid) resp++;
      if (done)
        chk("rd_complete", int'(state), rmw ? int'(ALU) : int'(WAIT_NACK));
      else
        chk("rd_wait_state", int'(state), int'(READ_WAIT));
      chk("rd_wait_resp", int'(resp_cnt), mn(resp, bl));
    end
    rd_data_valid = 1'b0;
    if (!rmw) begin
      step();
      chk("nack_to_idle", int'(state), int'(IDLE));
    end
  endtask

  task automatic alu_phase(input int wait_n, input int bl);
    for (int i = 0; i < wait_n; i++) begin
      step();
      chk("alu_wait", int'(state), int'(ALU));
    end
    rmw_hit = 1'b1;
    step();
    rmw_hit = 1'b0;
    chk("alu_pipe_entry", int'(state), int'(ALU_PIPE));
    for (int i = 1; i < ALAT; i++) begin
      step();
      chk("alu_pipe_hold", int'(state), int'(ALU_PIPE));
    end
    step();
    chk("tramp", int'(state), int'(WRITE_TRAMP));
    step();
    chk("tramp_to_write", int'(state), int'(WRITE));
    chk("tramp_req_clr", int'(req_cnt), 0);
    chk("tramp_resp_clr", int'(resp_cnt), 0);
    write_phase(bl);
  endtask

  task automatic refresh_phase(input bit with_fifo, input int hold);
    ref_req = 1'b1;
    fifo_v  = with_fifo;
    fifo_out = '0;
    fifo_out.cmd = CMD_STORE;
    fifo_out.cyc = 1'b1;
    fifo_out.we  = 1'b1;
    step();
    chk("ref_entry", int'(state), int'(REFRESH));
    chk("ref_ack_hi", int'(ref_ack), 1);
    ref_req = 1'b0;
    fifo_v  = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("ref_hold_ack", int'(ref_ack), 1);
    end
    app_ref_ack = 1'b1;
    step();
    app_ref_ack = 1'b0;
    chk("ref_exit", int'(state), int'(IDLE));
    chk("ref_ack_lo", int'(ref_ack), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad;
    rst = 1'b0; calib_complete = 1'b1; rst_busy = 1'b0; ref_req = 1'b0;
    app_ref_ack = 1'b0; rdy = 1'b0; wdf_rdy = 1'b0; fifo_v = 1'b0;
    fifo_out = '0; burst_len = '0; rd_data_valid = 1'b0; rmw_hit = 1'b0;
    step();
    step();
    chk_quiet("reset");
    rst = 1'b1;
    step();
    chk("idle_no_req", int'(state), int'(IDLE));

    // Reset in the middle of a read burst.
    issue(CMD_LOAD, 1'b1, 1'b0, 7);
    rdy = 1'b1;
    step();
    step();
    chk("pre_reset_req", int'(req_cnt), 2);
    rdy = 1'b0;
    rst = 1'b0;
    step();
    chk_quiet("mid_reset");
    step();
    step();
    rst = 1'b1;
    step();
    chk_quiet("post_reset");

    // Refresh beats a waiting command.
    refresh_phase(1'b1, 3);

    // FIFO still resetting holds the sequencer off.
    rst_busy = 1'b1;
    fifo_v   = 1'b1;
    step();
    chk("rst_busy_idle", int'(state), int'(IDLE));
    fifo_v   = 1'b0;
    rst_busy = 1'b0;

    // Write burst of 4 with a write-data stall.
    q_rdy = '{1, 1, 1, 1, 1};
    q_wd  = '{1, 0, 1, 1, 1};
    issue(CMD_STORE, 1'b1, 1'b1, 3);
    write_phase(3);

    // Read burst of 8: two request stalls, early responses, last rdy with a response.
    q_rdy = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    q_rdv = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    issue(CMD_LOAD, 1'b1, 1'b0, 7);
    read_phase(7, 1'b0);

    // Single-beat CAS through the ALU path.
    q_rdy = '{1};
    q_rdv = '{0, 0, 1};
    issue(CMD_CAS, 1'b1, 1'b0, 0);
    read_phase(0, 1'b1);
    q_rdy = '{1};
    q_wd  = '{1};
    alu_phase(5, 0);

    // Hang in READ_CMD: two requests and one response, then rdy stuck low.
    issue(CMD_LOAD, 1'b1, 1'b0, 3);
    for (int i = 1; i < TO; i++) begin
      rdy = (i <= 2);
      rd_data_valid = (i == 2);
      step();
      chk("hang_state", int'(state), int'(READ_CMD));
      chk("hang_no_to", int'(timeout), 0);
    end
    rdy = 1'b0;
    rd_data_valid = 1'b0;
    step();
    chk("to_pulse", int'(timeout), 1);
    chk("to_state", int'(state), int'(IDLE));
    chk("to_req_clr", int'(req_cnt), 0);
    chk("to_resp_clr", int'(resp_cnt), 0);
    step();
    chk("to_one_cycle", int'(timeout), 0);
    chk("to_stay_idle", int'(state), int'(IDLE));

    // Uncalibrated: nothing starts, nothing times out.
    calib_complete = 1'b0;
    fifo_v  = 1'b1;
    ref_req = 1'b1;
    fifo_out.cyc = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (state != IDLE || timeout || ref_ack) bad++;
    end
    chk("uncal_idle", bad, 0);
    fifo_v  = 1'b0;
    ref_req = 1'b0;
    calib_complete = 1'b1;
    step();

    // Randomized transaction mix.
    for (int t = 0; t < 40; t++) begin
      int kind;
      int bl;
      kind = $urandom_range(0, 4);
      bl   = $urandom_range(0, 7);
      case (kind)
        0: begin issue(CMD_STORE, 1'b1, 1'b1, bl); write_phase(bl); end
        1: begin issue(CMD_LOAD, 1'b1, 1'b0, bl); read_phase(bl, 1'b0); end
        2: begin
          issue(fta_cmd_t'($urandom_range(int'(CMD_ADD), int'(CMD_CAS))), 1'b1, 1'b0, bl);
          read_phase(bl, 1'b1);
          alu_phase($urandom_range(0, 8), bl);
        end
        3: refresh_phase($urandom_range(0, 1) != 0, $urandom_range(0, 8));
        default: issue(CMD_NOP, 1'b0, 1'b0, bl);
      endcase
      chk("rand_no_timeout", int'(timeout), 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mpmc12_state_machine_fta.md
# mpmc12_state_machine_fta

Parametrised controller sequencer for the mpmc12 multi-port memory controller. Sits between the command FIFO (fta_cmd_request256_t entries) and the DDR application interface. Sequences refresh, burst writes, pipelined burst reads and read-modify-write (ALU) commands. Unlike the mpmc11 sequencer, it owns its burst counters and hang timeout, and arbitrates refresh in hardware.

## Interface
- BLW, 6: burst-length/counter width.
- PRESET_CYCLES, 3: FIFO settle cycles before decode (≥1).
- ALU_LATENCY, 4: cycles from rmw_hit to WRITE_TRAMP (≥1).
- TO_CYCLES, 1023: hang timeout, in cycles spent in one non-IDLE state.
- REFRESH_EN, 1: enables the REFRESH path.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-low.
- calib_complete  in  1  PHY calibration done.
- rst_busy  in  1  FIFO reset in progress.
- ref_req  in  1  refresh request.
- ref_ack  out  1  refresh issued to the PHY.
- app_ref_ack  in  1  PHY refresh done.
- rdy  in  1  app command accept.
- wdf_rdy  in  1  write-data FIFO accept.
- fifo_v  in  1  command FIFO non-empty.
- fifo_out  in  fta_cmd_request256_t  head command.
- burst_len  in  BLW  beats minus one.
- rd_data_valid  in  1  read beat returned.
- rmw_hit  in  1  RMW data latched by the datapath.
- state  out  mpmc12_state_t  current state.
- app_en  out  1  command strobe.
- app_wdf_wren  out  1  write-data strobe.
- req_cnt  out  BLW  accepted request beats.
- resp_cnt  out  BLW  received response beats.
- timeout  out  1  one-cycle hang pulse.

## Operation
- IDLE
  - With calib_complete=0, stays in IDLE.
  - If REFRESH_EN and ref_req: go to REFRESH. Refresh has priority over fifo_v.
  - Otherwise, if !rst_busy and fifo_v: go to PRESET.
- REFRESH
  - ref_ack=1 throughout.
  - On app_ref_ack: go to IDLE; ref_ack drops the same edge.
- PRESET
  - Held for PRESET_CYCLES cycles.
  - On entry: req_cnt and resp_cnt clear, and burst_len is latched to bl_q. bl_q is used for the whole command.
  - Decode: cyc&we → WRITE; cyc only → READ_CMD; cyc=0 → IDLE.
- WRITE
  - app_en=app_wdf_wren=1.
  - A beat is accepted when rdy&wdf_rdy; req_cnt then increments.
  - After the beat accepted with req_cnt==bl_q: go to IDLE.
- READ_CMD
  - app_en=1; each rdy increments req_cnt.
  - After the beat accepted with req_cnt==bl_q: go to READ_WAIT.
- Response counting
  - In READ_CMD and READ_WAIT, each rd_data_valid increments resp_cnt. Responses may arrive before all requests are issued.
- READ_WAIT
  - Completes when rd_data_valid && resp_cnt==bl_q.
  - If fifo_out.cmd is an RMW command (ADD, OR, AND, EOR, ASL, LSR, MIN, MAX, MINU, MAXU, CAS): go to ALU. Otherwise go to WAIT_NACK.
- ALU
  - Waits for rmw_hit, then spends ALU_LATENCY cycles in ALU_PIPE, then goes to WRITE_TRAMP.
  - WRITE_TRAMP clears the counters and goes to WRITE.
- WAIT_NACK → IDLE.
- Timeout
  - Counter clears on every state change and while in IDLE.
  - Reaching TO_CYCLES with calib_complete=1 pulses timeout. Next state is forced to IDLE, ref_ack clears, counters clear.
  - The timeout override beats every other transition.
- Counter width
  - Counters are BLW bits and saturate at bl_q; they never wrap.
  - bl_q=0 gives a single-beat burst.

## Timing
- Reset (rst=0 at a clk edge)
  - state=IDLE; all outputs 0; timeout counter 0.
  - Applies mid-burst too, with no completion.
- All outputs are registered or decoded from state alone. No input reaches an output combinationally except app_en, app_wdf_wren = f(state).
- Minimum command latency, fifo_v to first app_en: 1 + PRESET_CYCLES cycles.
- Single-beat write with rdy=wdf_rdy=1: WRITE lasts 1 cycle.
- Simultaneous rd_data_valid and the last rdy in READ_CMD: both counters advance; the state moves to READ_WAIT. Completion is evaluated in READ_WAIT only.
- Simultaneous ref_req and fifo_v in IDLE: REFRESH first.

## Structure
- mpmc12_pkg holds:
  - mpmc12_state_t (4-bit enum: IDLE, REFRESH, PRESET, WRITE, READ_CMD, READ_WAIT, ALU, ALU_PIPE, WRITE_TRAMP, WAIT_NACK).
  - is_rmw_cmd() function.
  - Default parameter constants.
- Sub-module mpmc12_hang_timer: parametrised counter with clear/enable and a one-cycle expiry pulse.

## Test plan
- Reset/refresh
  - Hold rst=0 for 3 cycles mid-READ_CMD → state=IDLE and all outputs 0 on the next edge.
  - Then ref_req with fifo_v → REFRESH, ref_ack=1; app_ref_ack → IDLE.
- Write burst, burst_len=3, wdf_rdy toggling 1,0,1,1,1 → exactly 4 accepted beats, then IDLE.
- Read burst, burst_len=7, rdy stalls 2 cycles, first rd_data_valid during READ_CMD → resp_cnt reaches 7, then WAIT_NACK, then IDLE.
- CMD_CAS, burst_len=0
  - Path: READ_WAIT → ALU; rmw_hit after 5 cycles.
  - Then ALU_PIPE for 4 cycles → WRITE_TRAMP → WRITE, with counters 0 on entering WRITE.
- Timeout: TO_CYCLES=15, rdy held 0 in READ_CMD → timeout pulse after 15 cycles, then IDLE.
- calib_complete=0 with fifo_v=1 for 100 cycles → stays IDLE, no timeout.
